noc_port_arbiter: RTL and testbench
===================================

Name: noc_port_arbiter

Overview:
- Clocked round-robin arbiter for one router output port. It shares that port among the five router input sources: left, right, up, down and pe_mem.
- Selects one valid requester per transfer and latches its 33-bit package into a single-entry output register. That register drives the downstream link.
- Lets the NoC router's output-port contention be implemented and verified in synthesizable RTL, separately from the CSP-level router model.

Parameters:
- WIDTH_PACKAGE, 33, package width in bits.
- N_REQ, 5, number of requesters. Index order: 0=left, 1=right, 2=up, 3=down, 4=pe_mem.
- PTR_W, $clog2(N_REQ), width of the round-robin pointer.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_REQ  per-requester request/valid.
- in_data  in  N_REQ*WIDTH_PACKAGE  packed packages; requester i occupies bits [i*WIDTH_PACKAGE +: WIDTH_PACKAGE].
- in_ready  out  N_REQ  one-hot or zero; in_ready[i] high means requester i's package is taken this cycle.
- out_valid  out  1  output register holds a package.
- out_data  out  WIDTH_PACKAGE  output register contents.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_src  out  PTR_W  index of the requester whose package is in the output register.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready=0 while rst_n=0.
- Handshakes:
  - A transfer on input i occurs when in_valid[i] && in_ready[i].
  - A transfer on the output occurs when out_valid && out_ready.
  - Requesters must hold in_valid and in_data stable until their transfer. in_valid may not drop before the transfer.
- can_accept = !out_valid || out_ready. The output register is either empty or draining this cycle, so full throughput is 1 package/cycle.
- Grant (combinational):
  - g = first index with in_valid set, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - in_ready[g] = can_accept && any(in_valid). All other bits of in_ready are 0.
- On an input transfer from g:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= (g==N_REQ-1) ? 0 : g+1.
- Output drains without a new input transfer: out_valid <= 0; out_data and out_src keep their old values.
- Simultaneous output drain and input transfer: register reloads, out_valid stays 1, no bubble.
- Full with out_ready=0: all in_ready=0, register and rr_ptr frozen.
- No valid requester: rr_ptr unchanged.
- Latency: package visible on out_data one cycle after its input transfer.
- Fairness: with all N_REQ requesting continuously and out_ready=1, grants rotate strictly. Each requester waits at most N_REQ-1 transfers.
- rr_ptr wraps from N_REQ-1 to 0; values >= N_REQ are unreachable.
- Reset mid-operation: the held package is discarded and the pointer returns to 0. An upstream package offered at reset remains with its requester, since no transfer occurred.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (N_REQ*16, per-requester 16-bit counters of input transfers).
  - Adds output stall_cnt (16, cycles with out_valid && !out_ready).
  - All counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package noc_arb_pkg holds:
  - WIDTH_PACKAGE default 33.
  - N_REQ=5.
  - Requester index constants: REQ_LEFT=0, REQ_RIGHT=1, REQ_UP=2, REQ_DOWN=3, REQ_PE=4.
  - package_t typedef logic [WIDTH_PACKAGE-1:0].
- One natural sub-module: rr_pick. It is a combinational rotate-priority-encoder taking (req, ptr) and returning (gnt_idx, gnt_any). The top keeps the output register, pointer and optional counters.

Test Plan:
- Reset check: drive rst_n=0 with in_valid=5'b11111 -> in_ready=0, out_valid=0, out_data=0. Release reset with only in_valid[2]=1 and data 33'h0_0000_00AA -> next cycle out_valid=1, out_data=33'hAA, out_src=2.
- Rotation: all five valid with data 33'h10+i, out_ready=1 -> out_src sequence 0,1,2,3,4,0; one package per cycle, no bubbles.
- Backpressure: fill register with 33'h1_2345_6789, hold out_ready=0 for 4 cycles with in_valid=5'b10001 -> in_ready=0 and out_data stable throughout. Raise out_ready -> drains, next grant follows the pointer.
- Skip idle: rr_ptr=1, in_valid=5'b00001 -> grant 0, rr_ptr becomes 1. Then in_valid=5'b10000 -> grant 4, rr_ptr wraps to 0.
- Simultaneous drain/load: out_valid=1, out_ready=1, in_valid[3]=1 data 33'h0_DEAD_BEEF -> same edge: old package consumed, out_data=33'hDEADBEEF, out_valid stays 1.
- Stats (NOC_ARB_STATS_EN defined): 20 grants to left, 3 stall cycles -> grant_cnt[0]=20, stall_cnt=3. Forced 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg
//   Shared constants and types for the NoC output-port arbiter.
//   - WIDTH_PACKAGE / N_REQ / PTR_W : default geometry of one router output port
//   - REQ_* : requester index constants (0=left .. 4=pe_mem)
//   - package_t : one NoC package
//   - CNT_W / CNT_MAX : width and saturation value of the optional statistics
//     counters (built only when NOC_ARB_STATS_EN is defined)
package noc_arb_pkg;

  localparam int WIDTH_PACKAGE = 33;
  localparam int N_REQ         = 5;
  localparam int PTR_W         = $clog2(N_REQ);

  localparam int REQ_LEFT  = 0;
  localparam int REQ_RIGHT = 1;
  localparam int REQ_UP    = 2;
  localparam int REQ_DOWN  = 3;
  localparam int REQ_PE    = 4;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [WIDTH_PACKAGE-1:0] package_t;

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotate-priority encoder. Scans req starting at index ptr
//   and wrapping modulo N_REQ; returns the first set index.
//   Ports:
//     req     in  N_REQ  request vector
//     ptr     in  PTR_W  highest-priority index this cycle (must be < N_REQ)
//     gnt_idx out PTR_W  winning index (0 when gnt_any=0)
//     gnt_any out 1      at least one request present
module rr_pick #(
  parameter int N_REQ = 5,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    // Walk from the lowest-priority offset up to offset 0 so the last
    // assignment made is the one closest to ptr.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        gnt_idx = PTR_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter
//   Round-robin arbiter for one router output port. Picks one valid requester
//   per cycle, latches its package into a single-entry output register and
//   advances the round-robin pointer past the winner.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_valid     per-requester valid (held until transferred)
//     in_data      packed packages, requester i at [i*WIDTH_PACKAGE +: WIDTH_PACKAGE]
//     in_ready     one-hot (or zero) grant; taken this cycle when in_valid&in_ready
//     out_valid    output register holds a package
//     out_data     output register contents
//     out_ready    downstream accepts out_data this cycle
//     out_src      index of requester whose package sits in the output register
//   Optional (macro NOC_ARB_STATS_EN):
//     grant_cnt    per-requester saturating 16-bit transfer counters
//     stall_cnt    saturating count of cycles with out_valid && !out_ready
//
//   Handshake: a transfer on any channel happens on a rising edge where both
//   valid and ready are high; the producer holds valid and data stable until
//   that edge, and ready never depends on anything registered downstream
//   beyond out_ready.
module noc_port_arbiter #(
  parameter int WIDTH_PACKAGE = noc_arb_pkg::WIDTH_PACKAGE,
  parameter int N_REQ         = noc_arb_pkg::N_REQ,
  parameter int PTR_W         = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           in_valid,
  input  logic [N_REQ*WIDTH_PACKAGE-1:0] in_data,
  output logic [N_REQ-1:0]           in_ready,
  output logic                       out_valid,
  output logic [WIDTH_PACKAGE-1:0]   out_data,
  input  logic                       out_ready,
  output logic [PTR_W-1:0]           out_src
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]        grant_cnt,
  output logic [15:0]                stall_cnt
`endif
);

  import noc_arb_pkg::*;

  logic                     out_valid_q, out_valid_d;
  logic [WIDTH_PACKAGE-1:0] out_data_q,  out_data_d;
  logic [PTR_W-1:0]         out_src_q,   out_src_d;
  logic [PTR_W-1:0]         rr_ptr_q,    rr_ptr_d;

  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             can_accept;
  logic             take;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // The register may accept when empty or when its package leaves this cycle.
  assign can_accept = !out_valid_q || out_ready;
  // rst_n gates the grant so no requester believes it transferred during reset.
  assign take       = gnt_any && can_accept && rst_n;

  always_comb begin
    in_ready    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (take) begin
      in_ready[gnt_idx] = 1'b1;
      out_valid_d       = 1'b1;
      out_data_d        = in_data[int'(gnt_idx)*WIDTH_PACKAGE +: WIDTH_PACKAGE];
      out_src_d         = gnt_idx;
      rr_ptr_d          = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef NOC_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (take && grant_cnt_q[gnt_idx] != CNT_MAX) begin
      grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + CNT_W'(1);
    end
    if (out_valid_q && !out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter
//   Directed steps followed by randomized traffic for noc_port_arbiter,
//   checked against a cycle-level reference model of the arbitration rules.
//   Statistics checks are built only when NOC_ARB_STATS_EN is defined.
module tb_noc_port_arbiter;
  import noc_arb_pkg::*;

  localparam int W = WIDTH_PACKAGE;
  localparam int N = N_REQ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data  = '0;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready = 1'b0;
  logic [PTR_W-1:0] out_src;
`ifdef NOC_ARB_STATS_EN
  logic [N*16-1:0]  grant_cnt;
  logic [15:0]      stall_cnt;
`endif

  noc_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef NOC_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  int       checks = 0;
  int       errors = 0;
  int       m_ptr;
  bit       m_valid;
  package_t m_data;
  int       m_src;
  int       last_g;
  package_t exp_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    last_g  = -1;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(int i, package_t d);
    in_valid[i]          = 1'b1;
    in_data[i*W +: W]    = d;
  endtask

  // One clock with inputs already applied: checks grant before the edge,
  // drained package at the edge, register contents after the edge.
  task automatic tick(string tag);
    int           g;
    logic [N-1:0] er;
    package_t     d;
    #1;
    g  = model_pick(in_valid, m_ptr);
    er = '0;
    if (g >= 0 && (!m_valid || out_ready)) er[g] = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
    if (m_valid && out_ready) begin
      d = exp_q.pop_front();
      chk({tag, ".drain"}, 64'(out_data), 64'(d));
      m_valid = 1'b0;
    end
    last_g = -1;
    if (er != '0) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_src   = g;
      m_ptr   = (g + 1) % N;
      last_g  = g;
      exp_q.push_back(m_data);
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
    chk({tag, ".out_src"},   64'(out_src),   64'(m_src));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst.in_ready",  64'(in_ready),  64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.out_data",  64'(out_data),  64'(0));
    chk("rst.out_src",   64'(out_src),   64'(0));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int exp_rot[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    model_reset();

    // Reset with everyone requesting: nothing may be granted.
    in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = package_t'(32'hC0 + i);
    apply_reset();
    in_valid = '0;
    set_req(REQ_UP, package_t'(33'h0_0000_00AA));
    out_ready = 1'b1;
    release_reset();
    tick("rst_rel");
    chk("rst_rel.data_aa", 64'(out_data), 64'h0AA);
    chk("rst_rel.src_up",  64'(out_src),  64'(REQ_UP));
    in_valid = '0;

    // Reset mid-operation discards the held package and pointer.
    apply_reset();
    release_reset();

    // Rotation: all five requesting continuously.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, package_t'(33'h10 + i));
    for (int s = 0; s < 6; s++) begin
      tick("rot");
      chk("rot.seq", 64'(out_src), 64'(exp_rot[s]));
      chk("rot.nobubble", 64'(out_valid), 64'(1));
    end
    in_valid = '0;

    // Backpressure: pointer is at 1 here.
    set_req(REQ_RIGHT, package_t'(33'h1_2345_6789));
    tick("bp_fill");
    in_valid = '0;
    out_ready = 1'b0;
    set_req(REQ_LEFT, package_t'(33'h0_0000_0A0A));
    set_req(REQ_PE,   package_t'(33'h0_0000_0E0E));
    for (int s = 0; s < 4; s++) begin
      tick("bp_hold");
      chk("bp_hold.stable", 64'(out_data), 64'h1_2345_6789);
    end
    out_ready = 1'b1;
    tick("bp_release");
    chk("bp_release.ptr_follow", 64'(out_src), 64'(REQ_PE));
    in_valid[REQ_PE] = 1'b0;
    tick("bp_next");
    chk("bp_next.left", 64'(out_src), 64'(REQ_LEFT));
    in_valid = '0;

    // Skip idle: pointer is at 1.
    set_req(REQ_LEFT, package_t'(33'h0_0000_0111));
    tick("skip_left");
    in_valid = '0;
    set_req(REQ_PE, package_t'(33'h1_0000_0444));
    tick("skip_pe");
    chk("skip_pe.src", 64'(out_src), 64'(REQ_PE));
    in_valid = '1;
    tick("skip_wrap");
    chk("skip_wrap.src0", 64'(out_src), 64'(REQ_LEFT));
    in_valid = '0;

    // Simultaneous drain and load.
    set_req(REQ_DOWN, package_t'(33'h0_DEAD_BEEF));
    tick("sim");
    chk("sim.data", 64'(out_data), 64'h0_DEAD_BEEF);
    chk("sim.valid", 64'(out_valid), 64'(1));
    in_valid = '0;

    // Randomized traffic, requesters holding until transferred.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 99) < 35)
          set_req(i, package_t'({$urandom(), $urandom()}));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick("rand");
      if (last_g >= 0) in_valid[last_g] = 1'b0;
    end
    in_valid = '0;

`ifdef NOC_ARB_STATS_EN
    apply_reset();
    release_reset();
    out_ready = 1'b1;
    set_req(REQ_LEFT, package_t'(33'h0_0000_0055));
    for (int s = 0; s < 20; s++) tick("st_grant");
    in_valid  = '0;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) tick("st_stall");
    chk("stats.grant0", 64'(grant_cnt[15:0]), 64'd20);
    chk("stats.stall3", 64'(stall_cnt), 64'd3);
    repeat (70000) @(posedge clk);
    #1;
    chk("stats.stall_sat", 64'(stall_cnt), 64'hFFFF);
    chk("stats.grant0_hold", 64'(grant_cnt[15:0]), 64'd20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
